// File: rtl/dsm2_dither_mod.sv
// rtl/dsm2_dither_mod.sv - second-order 1-bit delta-sigma modulator with optional dither
// Optional feature macro: DSM_DITHER_EN adds the shifted +/-1 dither at the quantizer input.
module dsm2_dither_mod #(
  parameter int DW           = 16,
  parameter int IW           = 24,
  parameter int OSR          = 64,
  parameter int DITHER_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ce,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    dither,
  input  logic          clr_status,
  output logic          dsm_out,
  output logic          underrun,
  output logic          sat_flag
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);
  localparam logic signed [IW+1:0] FS_W    = {{(IW+2-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic signed [IW+1:0] SAT_MAX = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [IW+1:0] SAT_MIN = {3'b111, {(IW-1){1'b0}}};

  logic signed [DW-1:0] nxt, cur;
  logic                 nxt_full;
  logic [CW-1:0]        osr_cnt;
  logic signed [IW-1:0] i1, i2;

  logic signed [IW+1:0] x_w, fb_w, s1, s2, d_s, qsum;
  logic signed [IW-1:0] i1n, i2n;
  logic                 clip1, clip2, accept, boundary;

  function automatic logic signed [IW-1:0] sat_f(input logic signed [IW+1:0] v);
    if (v > SAT_MAX) return SAT_MAX[IW-1:0];
    if (v < SAT_MIN) return SAT_MIN[IW-1:0];
    return v[IW-1:0];
  endfunction

`ifdef DSM_DITHER_EN
  always_comb begin
    d_s = '0;
    if (dither == 2'b01)      d_s = (IW+2)'(1) <<< DITHER_SHIFT;
    else if (dither == 2'b11) d_s = -((IW+2)'(1) <<< DITHER_SHIFT);
  end
`else
  logic unused_dither;
  assign unused_dither = ^dither;
  assign d_s = '0;
`endif

  always_comb begin
    x_w   = (IW+2)'(cur);
    fb_w  = dsm_out ? FS_W : -FS_W;
    s1    = (IW+2)'(i1) + x_w - fb_w;
    clip1 = (s1 > SAT_MAX) || (s1 < SAT_MIN);
    i1n   = sat_f(s1);
    s2    = (IW+2)'(i2) + (IW+2)'(i1n) - fb_w;
    clip2 = (s2 > SAT_MAX) || (s2 < SAT_MIN);
    i2n   = sat_f(s2);
    qsum  = (IW+2)'(i2n) + d_s;
  end

  assign in_ready = !nxt_full;
  assign accept   = in_valid && !nxt_full;
  assign boundary = ce && (osr_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      nxt      <= '0;
      nxt_full <= 1'b0;
      cur      <= '0;
      osr_cnt  <= '0;
      i1       <= '0;
      i2       <= '0;
      dsm_out  <= 1'b0;
      underrun <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      // accept implies an empty buffer, so it never collides with the boundary hand-off
      if (accept) begin
        nxt      <= in_data;
        nxt_full <= 1'b1;
      end else if (boundary && nxt_full) begin
        nxt_full <= 1'b0;
      end

      if (boundary && nxt_full) cur <= nxt;

      if (ce) begin
        osr_cnt <= (osr_cnt == LAST) ? '0 : osr_cnt + CW'(1);
        i1      <= i1n;
        i2      <= i2n;
        dsm_out <= !qsum[IW+1];
      end

      if (boundary && !nxt_full) underrun <= 1'b1;
      else if (clr_status)       underrun <= 1'b0;

      if (ce && (clip1 || clip2)) sat_flag <= 1'b1;
      else if (clr_status)        sat_flag <= 1'b0;
    end
  end

endmodule

// File: doc/dsm2_dither_mod.md
# dsm2_dither_mod

Second-order, 1-bit delta-sigma modulator stage of the DAC digital path. It takes oversampled PCM words from the interpolation chain over a valid/ready handshake and holds each word for OSR modulator ticks. At the quantizer input it adds the ±1 dither sequence from the 18-tap dither generator, and it emits the 1-bit bitstream that drives the analog DAC cell. It also reports input underrun and integrator saturation as sticky status.

## Interface
- DW, 16: input sample width, signed two's complement.
- IW, 24: integrator width, signed; must satisfy IW ≥ DW+4.
- OSR, 64: modulator ticks per input sample; must be ≥ 2.
- DITHER_SHIFT, 4: left shift applied to the ±1 dither before the quantizer.

- clk  input  1  clock; single clock domain.
- rstn  input  1  reset; synchronous, active-low.
- ce  input  1  modulator tick enable; all modulator/OSR state advances only when ce=1.
- in_data  input  DW  PCM sample from the interpolator.
- in_valid  input  1  in_data valid.
- in_ready  output  1  one-entry input buffer empty.
- dither  input  2  signed dither from the dither generator; 2'b01=+1, 2'b11=−1, any other code treated as 0.
- clr_status  input  1  clears underrun and sat_flag.
- dsm_out  output  1  modulator bit; 1 = +FS, 0 = −FS.
- underrun  output  1  sticky: OSR boundary reached with no buffered sample.
- sat_flag  output  1  sticky: an integrator clipped.

## Operation
- FS = 2^(DW−1), sign-extended to IW. Feedback fb = dsm_out ? +FS : −FS. x = cur sign-extended to IW.
- d_s = (DSM_DITHER_EN ? d : 0) <<< DITHER_SHIFT, sign-extended to IW+2.
- Input buffer:
  - Holds nxt and nxt_full; in_ready = !nxt_full.
  - On in_valid && in_ready: nxt ← in_data and nxt_full ← 1.
- OSR counter osr_cnt runs 0..OSR−1 and advances only on ce. A boundary is ce && osr_cnt==OSR−1. At a boundary:
  - nxt_full=1: cur ← nxt, nxt_full ← 0.
  - nxt_full=0: cur keeps its value and underrun ← 1.
  - A sample accepted in the boundary cycle itself lands in nxt, not cur, so that boundary still counts as an underrun.
- Modulator, on each ce:
  - i1' = sat(i1 + x − fb).
  - i2' = sat(i2 + i1' − fb).
  - dsm_out ← (i2' + d_s ≥ 0).
  - Sums are computed at IW+2 bits. sat() clips to [−2^(IW−1), 2^(IW−1)−1]; any clip sets sat_flag.
- Status: clr_status clears both flags. If a set event and clr_status occur in the same cycle, set wins.
- With ce=0, all modulator/OSR state and dsm_out hold. The input handshake stays active.

## Timing
- Reset values:
  - dsm_out=0, in_ready=1 (nxt_full=0), underrun=0, sat_flag=0.
  - i1=i2=0, cur=0, osr_cnt=0.
- dsm_out is registered and updates the cycle after the ce cycle that computes it.
- A sample accepted at cycle t becomes cur at the first boundary after t, and affects dsm_out one cycle after that boundary.
- Only one sample can be in flight: in_ready drops the cycle after acceptance and rises the cycle after the boundary that consumes it.
- rstn low on any clock edge returns every register to its reset value within that edge, regardless of ce or handshake activity. A sample offered in the reset cycle is dropped.
- Back-to-back ce=1 sustains one output bit per cycle.

## Configuration
- DSM_DITHER_EN defined: d_s is added at the quantizer input as described.
- DSM_DITHER_EN undefined:
  - d_s = 0 and the dither port is ignored (port remains, unused).
  - The quantizer reduces to (i2' ≥ 0).
  - The bitstream is then fully deterministic from the input samples.

## Test plan
- Reset check: hold rstn=0 for 3 cycles with in_valid=1 → dsm_out=0, in_ready=1, underrun=0, sat_flag=0. First post-reset ce ticks with x=0, dither off → dsm_out sequence 1,1,0,1.
- Zero-input density: x=0, ce=1 continuously, DSM_DITHER_EN on, dither from generator → ones count in 1024 ticks = 512±4, sat_flag=0.
- Half-scale DC: x=+FS/2 (0x4000 for DW=16), samples always supplied → ones count in 1024 ticks = 768±8, underrun=0.
- Underrun: supply one sample, then in_valid=0 for 2·OSR ticks → underrun=1 at the second boundary, cur keeps the last value. Then clr_status=1 → underrun=0 next cycle.
- ce gating: ce toggling 1,0,0,1 → dsm_out and osr_cnt change only after ce=1 cycles. in_ready still rises and falls with handshakes during ce=0.
- Saturation and reset mid-run: x=+FS−1 for 4096 ticks → sat_flag=1. Assert rstn=0 for 1 cycle mid-run → all outputs at reset values on the next cycle.
